// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: iterative AES SubBytes that substitutes LANES bytes per cycle through shared S-box lanes
module aes_sub_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_byte = SBOX[in_byte];
endmodule

module aes_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int N = 16 / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [7:0] sb_in [LANES];
  logic [7:0] sb_out [LANES];
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("LANES must be 1, 2, 4, 8 or 16");
  end
  // byte 0 sits in the top octet, so byte b lives at bits 8*(15-b) +: 8
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sb_in[k] = st_q[8 * (15 - LANES * int'(cnt_q) - k) +: 8];
    aes_sub_sbox u_sbox (.in_byte(sb_in[k]), .out_byte(sb_out[k]));
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    st_d = st_q;
    case (state_q)
      IDLE: if (in_valid) begin
        st_d = in_state;
        cnt_d = '0;
        state_d = SUB;
      end
      SUB: begin
        for (int i = 0; i < LANES; i++) st_d[8 * (15 - LANES * int'(cnt_q) - i) +: 8] = sb_out[i];
        cnt_d = cnt_q == CW'(N - 1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(N - 1) ? DONE : SUB;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_state = st_q;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb_aes_sub_bytes_seq: directed checks of aes_sub_bytes_seq across all LANES values against a GF(2^8) S-box model
module tb_aes_sub_bytes_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] iv = '0;
  logic [4:0] ordy = '1;
  logic [4:0] ir, ov, bz;
  logic [127:0] ist = '0;
  logic [127:0] os [5];
  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [7:0] sb [256];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_sub_bytes_seq #(.LANES(1 << g)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .in_state(ist),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_state(os[g]), .busy(bz[g])
    );
  end
  function automatic logic [7:0] gmul(input logic [7:0] a0, input logic [7:0] b0);
    logic [7:0] a, b, p;
    a = a0;
    b = b0;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox_math(input logic [7:0] a);
    logic [7:0] v;
    v = '0;
    for (int b = 1; b < 256; b++) if (gmul(a, 8'(b)) == 8'h01) v = 8'(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_ref(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[x[8*i +: 8]];
    return r;
  endfunction
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run_one(input int d, input logic [127:0] x, output int lat, output logic [127:0] res);
    iv[d] = 1'b1;
    ist = x;
    cyc();
    iv[d] = 1'b0;
    lat = 0;
    while (!ov[d] && lat < 40) begin
      cyc();
      lat++;
    end
    res = os[d];
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, acc, got, last, c;
    logic seen, stop;
    logic [127:0] res, x, x1, x2;
    logic [127:0] expq [$];
    for (int i = 0; i < 256; i++) sb[i] = sbox_math(8'(i));
    check("ref_sanity", sub_ref(128'h00112233445566778899aabbccddeeff), 128'h638293c31bfc33f5c4eeacea4bc12816);
    cyc();
    cyc();
    rst = 1'b0;
    for (int d = 0; d < 5; d++) begin
      check("rst_in_ready", ir[d], 1'b1);
      check("rst_out_valid", ov[d], 1'b0);
      check("rst_busy", bz[d], 1'b0);
      check("rst_out_state", os[d], '0);
    end
    run_one(2, 128'h00112233445566778899aabbccddeeff, lat, res);
    check("fips_latency", lat, 4);
    check("fips_out", res, 128'h638293c31bfc33f5c4eeacea4bc12816);
    cyc();
    check("fips_back_idle", ir[2], 1'b1);
    for (int d = 0; d < 5; d++) begin
      run_one(d, '0, lat, res);
      check("zero_latency", lat, 16 >> d);
      check("zero_out", res, {16{8'h63}});
      cyc();
    end
    x1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    x2 = 128'hdeadbeef0123456789abcdeffedcba98;
    ordy[2] = 1'b0;
    run_one(2, x1, lat, res);
    check("bp_out_valid_first", ov[2], 1'b1);
    iv[2] = 1'b1;
    ist = x2;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_hold_state", os[2], sub_ref(x1));
      check("bp_in_ready_low", ir[2], 1'b0);
      check("bp_out_valid_high", ov[2], 1'b1);
    end
    ordy[2] = 1'b1;
    cyc();
    check("bp_release_idle", ir[2], 1'b1);
    check("bp_release_no_load", os[2], sub_ref(x1));
    cyc();
    iv[2] = 1'b0;
    check("bp_second_busy", bz[2], 1'b1);
    check("bp_second_loaded", os[2], x2);
    lat = 0;
    while (!ov[2] && lat < 40) begin
      cyc();
      lat++;
    end
    check("bp_second_latency", lat, 4);
    check("bp_second_out", os[2], sub_ref(x2));
    cyc();
    iv[0] = 1'b1;
    ist = 128'h00000000000000000000000000000000 | 128'h1122334455667788_99aabbccddeeff00;
    cyc();
    iv[0] = 1'b0;
    cyc();
    cyc();
    check("mid_sub_busy", bz[0], 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_in_ready", ir[0], 1'b1);
    check("abort_out_valid", ov[0], 1'b0);
    check("abort_out_state", os[0], '0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      seen = seen | ov[0];
    end
    check("abort_no_pulse", seen, 1'b0);
    x = 128'h3243f6a8885a308d313198a2e0370734;
    run_one(0, x, lat, res);
    check("after_abort_latency", lat, 16);
    check("after_abort_out", res, sub_ref(x));
    cyc();
    rst = 1'b1;
    iv[1] = 1'b1;
    ist = x;
    cyc();
    rst = 1'b0;
    iv[1] = 1'b0;
    check("rst_prio_in_ready", ir[1], 1'b1);
    check("rst_prio_busy", bz[1], 1'b0);
    check("rst_prio_state", os[1], '0);
    cyc();
    check("rst_prio_not_accepted", bz[1], 1'b0);
    acc = 0;
    got = 0;
    last = -1;
    c = 0;
    stop = 1'b0;
    iv[1] = 1'b1;
    while (got < 100 && c < 3000) begin
      if (ov[1] && expq.size() > 0) begin
        check("b2b_out", os[1], expq.pop_front());
        got++;
      end
      if (ir[1] && iv[1]) begin
        if (last >= 0) check("b2b_gap", c - last, 10);
        last = c;
        ist = {$urandom(), $urandom(), $urandom(), $urandom()};
        expq.push_back(sub_ref(ist));
        acc++;
        stop = acc == 100;
      end
      cyc();
      c++;
      if (stop) iv[1] = 1'b0;
    end
    check("b2b_accepts", acc, 100);
    check("b2b_results", got, 100);
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) x[8*(15-i) +: 8] = 8'(16 * j + i);
      run_one(4, x, lat, res);
      check("exh_latency", lat, 1);
      for (int i = 0; i < 16; i++) check("exh_byte", res[8*(15-i) +: 8], sb[16 * j + i]);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
